// File: rtl/fetch_decode_queue_pkg.sv
// Shared types and constants for the fetch-to-decode elastic queue.
package fetch_decode_queue_pkg;

  localparam logic [31:0] nop_instr = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Fetch-side and decode-side handshake bundle for the fetch/decode queue.
interface fetch_decode_queue_if;

  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  // master: the fetch/decode environment around the queue
  modport master (
    output if_valid, if_instr, if_pc, flush, id_ready,
    input  if_ready, id_valid, id_instr, id_pc
  );

  modport slave (
    input  if_valid, if_instr, if_pc, flush, id_ready,
    output if_ready, id_valid, id_instr, id_pc
  );

endinterface

// File: rtl/fetch_decode_queue_mem.sv
// Register-array storage for the queue: one write port, one combinational read port.
module fetch_queue_mem
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_pkt_t    wdata,
  input  logic [AW-1:0] raddr,
  output fetch_pkt_t    rdata
);

  // Contents are deliberately not reset; the control logic never exposes stale entries.
  fetch_pkt_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Elastic IF/ID buffer: absorbs decode stalls, drives fetch back-pressure, presents NOPs when empty.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = nop_instr
) (
  input  logic                       clk,
  input  logic                       nrst,
  fetch_decode_queue_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [31:0]                bubble_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   bubble_q;

  logic       push;
  logic       pop;
  logic       starve;
  fetch_pkt_t wdata;
  fetch_pkt_t head;

  // Explicit wrap compare keeps non-power-of-2 depths legal.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign bus.if_ready = (count_q < DEPTH_C);
  assign bus.id_valid = (count_q != '0);

  assign push   = bus.if_valid & bus.if_ready & ~bus.flush;
  assign pop    = bus.id_valid & bus.id_ready & ~bus.flush;
  assign starve = bus.id_ready & ~bus.id_valid & ~bus.flush;

  assign wdata.instr = bus.if_instr;
  assign wdata.pc    = bus.if_pc;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  assign bus.id_instr = bus.id_valid ? head.instr : NOP_INSTR;
  assign bus.id_pc    = bus.id_valid ? head.pc    : 32'd0;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (bus.flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst)       bubble_q <= '0;
    else if (starve) bubble_q <= sat_inc32(bubble_q);
  end

  assign occupancy  = count_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Elastic buffer between the fetch unit and the decode stage. Replaces the bare IF/ID pipeline register.
- Accepts one instruction/PC pair per cycle from fetch and presents the oldest pair to decode.
- Drives fetch back-pressure (the fetch unit's pc_en) and inserts NOP bubbles on flush or when empty.
- Decouples decode stalls from fetch, so a cache hit is not lost while decode is stalled.

Parameters:
- DEPTH, 2, number of entries; must be at least 2. DEPTH=2 sustains one instruction per cycle.
- NOP_INSTR, 32'h00000013, instruction word presented to decode when no valid entry exists (addi x0,x0,0).

Ports:
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- if_valid  in  1  fetch offers a valid word; top level drives it with ~miss_cache
- if_instr  in  32  fetched instruction word
- if_pc  in  32  fetch PC value (PC+4 of the fetched word), stored unmodified
- flush  in  1  redirect/misprediction (chng2nop); kills all queued and incoming words
- id_ready  in  1  decode can consume this cycle (~decode stall)
- if_ready  out  1  queue can accept; drives fetch pc_en
- id_valid  out  1  id_instr/id_pc hold a real instruction
- id_instr  out  32  head instruction, or NOP_INSTR when id_valid=0
- id_pc  out  32  head PC, or 0 when id_valid=0
- occupancy  out  $clog2(DEPTH+1)  current entry count
- bubble_cnt  out  32  performance counter of decode starvation cycles

Behaviour:
- Reset (nrst=0 at posedge clk):
  - count, rd_ptr, wr_ptr = 0; bubble_cnt = 0.
  - Outputs: id_valid=0, id_instr=NOP_INSTR, id_pc=0, if_ready=1, occupancy=0.
  - Reset mid-operation discards all entries; no partial state survives.
- if_ready = (count < DEPTH). It depends on registered count only; there is no combinational path from id_ready.
- push = if_valid & if_ready & ~flush. The entry is written at wr_ptr; wr_ptr advances.
- pop = id_valid & id_ready & ~flush. rd_ptr advances.
- Pointers wrap from DEPTH-1 to 0 by explicit compare, so non-power-of-2 DEPTH is legal.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Push and pop in the same cycle is legal at any count below DEPTH.
- Outputs are driven combinationally from the storage head (mem[rd_ptr]) and registered count. There is no extra output register.
  - id_valid = (count != 0).
  - When count=0: id_instr=NOP_INSTR, id_pc=0.
- Latency: a word pushed at edge N appears on id_* after edge N (1 cycle) when the queue was empty.
- Full queue: if_ready=0, if_valid is ignored, and fetch holds its PC via pc_en.
- Empty queue with id_ready=1: no pop, NOP presented, bubble recorded.
- flush (highest priority, synchronous):
  - Next cycle count=0 and rd_ptr=wr_ptr=0.
  - The same-cycle if_valid word is dropped.
  - The same-cycle head is not counted as consumed (pop suppressed).
  - id_valid=0 and NOP_INSTR appear the cycle after the flush.
- flush while empty: no effect besides pointer clear.
- flush and reset together: reset wins; results are identical.
- bubble_cnt increments by 1 on each cycle with id_ready=1, id_valid=0, and flush=0. It saturates at 32'hFFFFFFFF and does not wrap.
- Storage contents are not reset; only pointers and count are. Stale data must never be visible because id_valid gates selection.

Decomposition:
- Shared constants package:
  - nop_instr constant (32'h00000013).
  - Packed struct fetch_pkt_t {logic[31:0] instr; logic[31:0] pc}.
- One sub-module, fetch_queue_mem: DEPTH x fetch_pkt_t register array with one write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
- Pointer, count, flush and counter control stay in fetch_decode_queue.

Test Plan:
- Streaming:
  - Stimulus: reset, then if_valid=1 with 0x00A00093/pc 0x4, 0x00B00113/pc 0x8, 0x00C00193/pc 0xC on consecutive cycles; id_ready=1.
  - Response: id_* shows each word one cycle after its push; occupancy stays at most 1; if_ready stays 1; bubble_cnt=1 (the first empty cycle).
- Decode stall / full:
  - Stimulus: id_ready=0, push 3 words.
  - Response: occupancy=2 and if_ready=0 after the second push; the third word is not accepted; id_instr holds the first word.
  - Stimulus: release id_ready.
  - Response: drains in order, first, second, then the re-offered third.
- Simultaneous push/pop at count=1:
  - Response: occupancy stays 1; the head advances to the next word each cycle; no word is lost or duplicated across 20 cycles of random data, checked by scoreboard.
- Flush:
  - Stimulus: with 2 entries queued, assert flush with if_valid=1 (0xDEADBEEF).
  - Response: next cycle occupancy=0, id_valid=0, id_instr=0x00000013, id_pc=0. 0xDEADBEEF is never presented. The next push after flush appears normally.
- Cache-miss bubbles:
  - Stimulus: if_valid=0 for 5 cycles with id_ready=1 and an empty queue.
  - Response: NOP presented; bubble_cnt increments by exactly 5.
  - Stimulus: force bubble_cnt to 32'hFFFFFFFE, then run 3 starvation cycles.
  - Response: bubble_cnt saturates at 32'hFFFFFFFF.
- Reset mid-operation:
  - Stimulus: with 2 entries queued and pointers wrapped, assert nrst=0 for one cycle.
  - Response: all outputs at reset values; the first subsequent push is presented correctly from entry 0.
